// File: rtl/tchain_pkg.sv
// tchain_pkg: shared state type and tick helpers for the timing-chain sequencer.
package tchain_pkg;
   typedef enum logic [1:0] {IDLE, RUN, WAIT} tchain_st_t;
   localparam int TICK_NS = 10;
   function automatic int ns2ticks(input int ns);
      return (ns + TICK_NS - 1) / TICK_NS;
   endfunction
endpackage

// File: rtl/tchain_seq_tcnt.sv
// tcnt: loadable down-counter with a terminal flag raised when the count is one.
module tcnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         dec,
   output logic [W-1:0] val,
   output logic         one
);
   always_ff @(posedge clk or posedge reset)
      if (reset) val <= '0;
      else if (load) val <= d;
      else if (dec) val <= val - W'(1);
   assign one = val == W'(1);
endmodule

// File: rtl/tchain_seq.sv
// tchain_seq: programmable chain of delay-separated one-cycle pulses with optional
// per-step stall on ack; start retriggers, abort kills.
module tchain_seq
   import tchain_pkg::*;
#(
   parameter int NSTEP = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     ack,
   input  logic [NSTEP*W-1:0]       dly,
   input  logic [NSTEP-1:0]         wait_mask,
   output logic [NSTEP-1:0]         step_p,
   output logic                     done,
   output logic                     busy,
   output logic [$clog2(NSTEP)-1:0] cur_step
);
   localparam int IW = $clog2(NSTEP);
   tchain_st_t st;
   logic [IW-1:0] idx, nxt, tgt;
   logic [W-1:0] cnt, raw, ld_val;
   logic one, pulse, last, load, dec;
   assign pulse  = st == RUN && one;
   assign last   = idx == IW'(NSTEP - 1);
   assign nxt    = idx + IW'(1);
   // The step whose delay is loaded this edge: step 0 on retrigger, the stalled step on ack, else the next one.
   assign tgt    = start ? '0 : st == WAIT ? idx : nxt;
   assign raw    = dly[int'(tgt)*W +: W];
   assign ld_val = raw == '0 ? W'(1) : raw;
   assign load   = !abort && (start ? !wait_mask[0] :
                              st == WAIT ? ack : pulse && !last && !wait_mask[nxt]);
   assign dec    = st == RUN && !load && cnt != '0;
   assign step_p = NSTEP'(pulse) << idx;
   assign done   = step_p[NSTEP-1];
   assign cur_step = idx;
   tcnt #(.W(W)) u_cnt (
      .clk(clk), .reset(reset), .load(load), .d(ld_val), .dec(dec), .val(cnt), .one(one)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st   <= IDLE;
         idx  <= '0;
         busy <= 1'b0;
      end else if (abort) begin
         st   <= IDLE;
         idx  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         st   <= wait_mask[0] ? WAIT : RUN;
         idx  <= '0;
         busy <= 1'b1;
      end else if (st == WAIT && ack) begin
         st <= RUN;
      end else if (pulse && last) begin
         st   <= IDLE;
         idx  <= '0;
         busy <= 1'b0;
      end else if (pulse) begin
         st  <= wait_mask[nxt] ? WAIT : RUN;
         idx <= nxt;
      end
endmodule

// File: tb/tb_tchain_seq.sv
// tb_tchain_seq: scenario and randomized checks of tchain_seq against a pulse-schedule model.
module tb_tchain_seq;
   logic clk = 0, reset = 0, start = 0, abort = 0, ack = 0;
   logic [31:0] dly;
   logic [3:0] wait_mask, step_p;
   logic done, busy;
   logic [1:0] cur_step;
   bit st_a[64], ab_a[64], ack_a[64];
   logic [7:0] dv[4];
   logic [3:0] wm_v;
   logic [3:0] e_sp[64];
   bit e_bz[64];
   int e_cs[64];
   int n_chk = 0, n_fail = 0;

   tchain_seq #(.NSTEP(4), .W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack), .dly(dly),
      .wait_mask(wait_mask), .step_p(step_p), .done(done), .busy(busy), .cur_step(cur_step)
   );

   always #5 clk = ~clk;

   // Each chain is a list of pulse cycles; later starts or aborts truncate it.
   function automatic void model(input int len);
      int kill, t, a;
      int p[4];
      for (int x = 0; x < 64; x++) begin
         e_sp[x] = 0; e_bz[x] = 0; e_cs[x] = 0;
      end
      for (int s = 0; s < len; s++) if (st_a[s] && !ab_a[s]) begin
         kill = len;
         for (int x = len - 1; x > s; x--) if (st_a[x] || ab_a[x]) kill = x;
         t = s;
         for (int k = 0; k < 4; k++) begin
            if (wm_v[k]) begin
               a = t + 1;
               while (a < len && !ack_a[a]) a++;
               t = a < len ? a : 1000;
            end
            p[k] = t + (dv[k] == 0 ? 1 : int'(dv[k]));
            t = p[k];
         end
         for (int x = s + 1; x <= kill && x < len && x <= p[3]; x++) begin
            e_bz[x] = 1;
            for (int k = 0; k < 4; k++) begin
               if (p[k] < x) e_cs[x]++;
               if (p[k] == x) e_sp[x][k] = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [7:0] ev(input int c);
      return {e_sp[c], e_sp[c][3], e_bz[c], 2'(e_cs[c])};
   endfunction

   task automatic clear();
      for (int i = 0; i < 64; i++) begin
         st_a[i] = 0; ab_a[i] = 0; ack_a[i] = 0;
      end
      dv = '{8'd3, 8'd5, 8'd1, 8'd2};
      wm_v = 0;
   endtask

   task automatic begin_scn(input int len);
      @(negedge clk);
      start = 0; abort = 0; ack = 0;
      dly = {dv[3], dv[2], dv[1], dv[0]};
      wait_mask = wm_v;
      reset = 1;
      #2 reset = 0;
      model(len);
   endtask

   task automatic step(input int c);
      @(negedge clk);
      start = st_a[c]; abort = ab_a[c]; ack = ack_a[c];
      #1;
   endtask

   task automatic test_reset_state();
      clear();
      begin_scn(8);
      for (int c = 0; c < 8; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state cycle %0d: got %b want 00000000", c, {step_p, done, busy, cur_step});
         end
      end
   endtask

   task automatic test_basic();
      clear();
      st_a[0] = 1;
      begin_scn(16);
      for (int c = 0; c < 16; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL basic cycle %0d: got %b want %b", c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
   endtask

   task automatic test_wait();
      clear();
      wm_v = 4'b0100;
      st_a[0] = 1;
      for (int i = 2; i <= 5; i++) ack_a[i] = 1;
      ack_a[20] = 1;
      begin_scn(30);
      for (int c = 0; c < 30; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL wait cycle %0d: got %b want %b", c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
   endtask

   task automatic test_abort(input bit with_start);
      clear();
      st_a[0] = 1;
      ab_a[6] = 1;
      st_a[6] = with_start;
      ack_a[6] = 1;
      begin_scn(16);
      for (int c = 0; c < 16; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL abort%0d cycle %0d: got %b want %b", with_start, c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
   endtask

   task automatic test_restart(input int at);
      clear();
      st_a[0] = 1;
      st_a[at] = 1;
      begin_scn(30);
      for (int c = 0; c < 30; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL restart%0d cycle %0d: got %b want %b", at, c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
   endtask

   task automatic test_zero_delay();
      clear();
      dv = '{8'd0, 8'd0, 8'd0, 8'd0};
      st_a[0] = 1;
      begin_scn(8);
      for (int c = 0; c < 8; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL zero_delay cycle %0d: got %b want %b", c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
   endtask

   task automatic test_async_reset();
      clear();
      st_a[0] = 1;
      begin_scn(16);
      for (int c = 0; c <= 6; c++) begin
         step(c);
         n_chk++;
         if ({step_p, done, busy, cur_step} !== ev(c)) begin
            n_fail++;
            $display("FAIL pre_reset cycle %0d: got %b want %b", c, {step_p, done, busy, cur_step}, ev(c));
         end
      end
      #1 reset = 1;
      #1;
      n_chk++;
      if ({step_p, done, busy, cur_step} !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: got %b want 00000000", {step_p, done, busy, cur_step});
      end
      @(negedge clk) reset = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         #1;
         n_chk++;
         if ({step_p, done, busy, cur_step} !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset cycle %0d: got %b want 00000000", c, {step_p, done, busy, cur_step});
         end
      end
   endtask

   task automatic test_random(input int iters);
      for (int it = 0; it < iters; it++) begin
         clear();
         for (int k = 0; k < 4; k++) dv[k] = 8'($urandom_range(0, 5));
         wm_v = 4'($urandom);
         st_a[0] = 1;
         for (int i = 1; i < 48; i++) begin
            st_a[i] = $urandom_range(0, 29) == 0;
            ab_a[i] = $urandom_range(0, 39) == 0;
            ack_a[i] = $urandom_range(0, 3) == 0;
         end
         begin_scn(48);
         for (int c = 0; c < 48; c++) begin
            step(c);
            n_chk++;
            if ({step_p, done, busy, cur_step} !== ev(c)) begin
               n_fail++;
               $display("FAIL random%0d cycle %0d: got %b want %b", it, c, {step_p, done, busy, cur_step}, ev(c));
            end
         end
      end
   endtask

   initial begin
      test_reset_state();
      test_basic();
      test_wait();
      test_abort(0);
      test_abort(1);
      test_restart(5);
      test_restart(11);
      test_zero_delay();
      test_async_reset();
      test_random(30);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
